// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment game display: state codes,
// active-low glyphs ({g,f,e,d,c,b,a}) and the code-to-glyph maps.
package seg7_pkg;

   typedef enum logic [3:0] {
      ST_READY    = 4'b0010,
      ST_QUESTION = 4'b0011,
      ST_INPUT    = 4'b0100,
      ST_DRAW     = 4'b0110,
      ST_WRONG    = 4'b0111,
      ST_GOOD     = 4'b1000,
      ST_OUCH     = 4'b1001,
      ST_WIN      = 4'b1010,
      ST_LOSE     = 4'b1011
   } seg7_state_e;

   localparam logic [6:0] GLYPH_0     = 7'b1000000;
   localparam logic [6:0] GLYPH_1     = 7'b1111001;
   localparam logic [6:0] GLYPH_2     = 7'b0100100;
   localparam logic [6:0] GLYPH_3     = 7'b0110000;
   localparam logic [6:0] GLYPH_4     = 7'b0011001;
   localparam logic [6:0] GLYPH_5     = 7'b0010010;
   localparam logic [6:0] GLYPH_6     = 7'b0000010;
   localparam logic [6:0] GLYPH_7     = 7'b1111000;
   localparam logic [6:0] GLYPH_8     = 7'b0000000;
   localparam logic [6:0] GLYPH_9     = 7'b0010000;
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
   localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
   localparam logic [6:0] GLYPH_R     = 7'b0101111;
   localparam logic [6:0] GLYPH_O     = 7'b1000000;
   localparam logic [6:0] GLYPH_A     = 7'b0001000;
   localparam logic [6:0] GLYPH_U     = 7'b1000001;
   localparam logic [6:0] GLYPH_T     = 7'b0000111;
   localparam logic [6:0] GLYPH_E     = 7'b0000110;

   function automatic logic [6:0] dec_glyph(input logic [3:0] code);
      logic [6:0] g;
      case (code)
         4'd0:    g = GLYPH_0;
         4'd1:    g = GLYPH_1;
         4'd2:    g = GLYPH_2;
         4'd3:    g = GLYPH_3;
         4'd4:    g = GLYPH_4;
         4'd5:    g = GLYPH_5;
         4'd6:    g = GLYPH_6;
         4'd7:    g = GLYPH_7;
         4'd8:    g = GLYPH_8;
         4'd9:    g = GLYPH_9;
         default: g = GLYPH_BLANK;
      endcase
      return g;
   endfunction

   // Player code n shows the last digit of the n-th prime; 0 means "not entered".
   function automatic logic [6:0] input_glyph(input logic [3:0] code);
      logic [6:0] g;
      case (code)
         4'd0:    g = GLYPH_DASH;
         4'd1:    g = GLYPH_2;
         4'd2:    g = GLYPH_3;
         4'd3:    g = GLYPH_5;
         4'd4:    g = GLYPH_7;
         4'd5:    g = GLYPH_1;
         4'd6:    g = GLYPH_3;
         4'd7:    g = GLYPH_7;
         4'd8:    g = GLYPH_9;
         4'd9:    g = GLYPH_3;
         default: g = GLYPH_BLANK;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational glyph selection for one digit position from the game state,
// the digit's code and its index.
module seg7_glyph
   import seg7_pkg::*;
(
   input  logic [3:0] i_state,
   input  logic [3:0] i_code,
   input  logic [2:0] i_digit_idx,
   input  logic       i_blank,
   output logic [6:0] o_glyph
);

   always_comb begin
      o_glyph = GLYPH_BLANK;
      case (i_state)
         ST_READY:    o_glyph = (i_digit_idx == 3'd0) ? GLYPH_R : GLYPH_BLANK;
         ST_QUESTION: o_glyph = dec_glyph(i_code);
         ST_INPUT:    o_glyph = i_blank ? GLYPH_BLANK : input_glyph(i_code);
         ST_DRAW:     o_glyph = GLYPH_T;
         ST_WRONG:    o_glyph = GLYPH_A;
         ST_GOOD:     o_glyph = GLYPH_O;
         ST_OUCH:     o_glyph = GLYPH_U;
         ST_WIN:      o_glyph = GLYPH_E;
         ST_LOSE:     o_glyph = GLYPH_O;
         default:     o_glyph = GLYPH_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_disp_n.sv
// NDIG-digit seven-segment game display with cursor blink. Defining
// SEG7_SCAN_EN adds a multiplexed (scanned) segment/anode output.
module seg7_disp_n
   import seg7_pkg::*;
#(
   parameter  int NDIG      = 4,
   parameter  int BLINK_DIV = 25000000,
   parameter  int SCAN_DIV  = 50000,
   localparam int CW        = (NDIG > 1) ? $clog2(NDIG) : 1
)(
   input  logic                CLK,
   input  logic                nRST,
   input  logic [3:0]          STATE,
   input  logic                LOAD,
   input  logic [4*NDIG-1:0]   DIN,
   input  logic [4*NDIG-1:0]   QUE,
   input  logic [CW-1:0]       CURSOR,
   output logic [7*NDIG-1:0]   nHEX,
   output logic [6:0]          nSEG,
   output logic [NDIG-1:0]     nAN
);

   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [4*NDIG-1:0] r_din, r_que;
   logic [4*NDIG-1:0] w_din_next, w_que_next;
   logic [3:0]        r_state_prev;
   logic [CW-1:0]     r_cursor_prev;
   logic [BW-1:0]     r_blink_cnt, w_blink_cnt_next;
   logic              r_phase, w_phase_next;
   logic              w_restart;
   logic [7*NDIG-1:0] r_nhex, w_glyph;

   assign w_din_next = LOAD ? DIN : r_din;
   assign w_que_next = LOAD ? QUE : r_que;
   assign w_restart  = (STATE != r_state_prev) || (CURSOR != r_cursor_prev);

   always_comb begin
      w_blink_cnt_next = r_blink_cnt;
      w_phase_next     = r_phase;
      if (w_restart) begin
         w_blink_cnt_next = '0;
         w_phase_next     = 1'b0;
      end else if (r_blink_cnt == BLINK_LAST) begin
         w_blink_cnt_next = '0;
         w_phase_next     = ~r_phase;
      end else begin
         w_blink_cnt_next = r_blink_cnt + 1'b1;
      end
   end

   // Decode from the next-cycle data/phase so freshly loaded data and a
   // restarted (visible) phase show on the same edge that captures them.
   for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      logic [3:0] w_code;
      logic       w_blank;
      assign w_code  = (STATE == ST_QUESTION) ? w_que_next[4*gi +: 4] : w_din_next[4*gi +: 4];
      assign w_blank = w_phase_next && (CURSOR == CW'(gi));
      seg7_glyph u_glyph (
         .i_state     (STATE),
         .i_code      (w_code),
         .i_digit_idx (3'(gi)),
         .i_blank     (w_blank),
         .o_glyph     (w_glyph[7*gi +: 7])
      );
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_din         <= '0;
         r_que         <= '0;
         r_state_prev  <= '0;
         r_cursor_prev <= '0;
         r_blink_cnt   <= '0;
         r_phase       <= 1'b0;
         r_nhex        <= '1;
      end else begin
         r_din         <= w_din_next;
         r_que         <= w_que_next;
         r_state_prev  <= STATE;
         r_cursor_prev <= CURSOR;
         r_blink_cnt   <= w_blink_cnt_next;
         r_phase       <= w_phase_next;
         r_nhex        <= w_glyph;
      end
   end

   assign nHEX = r_nhex;

`ifdef SEG7_SCAN_EN
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   logic [SW-1:0]   r_scan_cnt;
   logic [CW-1:0]   r_scan_idx;
   logic [6:0]      r_nseg;
   logic [NDIG-1:0] r_nan;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_scan_cnt <= '0;
         r_scan_idx <= '0;
         r_nseg     <= 7'h7F;
         r_nan      <= '1;
      end else begin
         r_nseg <= r_nhex[7*int'(r_scan_idx) +: 7];
         r_nan  <= ~(NDIG'(1) << r_scan_idx);
         if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_scan_idx <= (r_scan_idx == CW'(NDIG - 1)) ? '0 : r_scan_idx + 1'b1;
         end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
         end
      end
   end

   assign nSEG = r_nseg;
   assign nAN  = r_nan;
`else
   assign nSEG = 7'h7F;
   assign nAN  = '1;
`endif

endmodule

// File: doc/seg7_disp_n.md
SEG7_DISP_N -- requirements
Module: seg7_disp_n

Interface
REQ-001 SHALL have parameter NDIG, default 4, meaning number of digits (1..8).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, meaning CLK cycles per blink half-period.
REQ-003 SHALL have parameter SCAN_DIV, default 50000, meaning CLK cycles per scanned digit slot.
REQ-004 SHALL have one clock and an asynchronous active-low reset: CLK input 1 (rising-edge clock); nRST input 1 (asynchronous, active-low reset).
REQ-005 SHALL have port STATE  input  4  game state: 0010 READY, 0011 QUESTION, 0100 INPUT, 0110 DRAW, 0111 WRONG, 1000 GOOD, 1001 OUCH, 1010 WIN, 1011 LOSE.
REQ-006 SHALL have port LOAD  input  1  one-cycle strobe that captures DIN and QUE.
REQ-007 SHALL have port DIN  input  4*NDIG  player digit codes, digit i at [4i+3:4i].
REQ-008 SHALL have port QUE  input  4*NDIG  question digits (BCD), same packing.
REQ-009 SHALL have port CURSOR  input  max(1,$clog2(NDIG))  index of the digit being edited.
REQ-010 SHALL have port nHEX  output  7*NDIG  registered active-low segments, digit i at [7i+6:7i].
REQ-011 SHALL have port nSEG  output  7  active-low scanned segment bus.
REQ-012 SHALL have port nAN  output  NDIG  active-low scanned digit enables.

Function
REQ-013 SHALL hold din_q and que_q registers, loaded from DIN and QUE on a cycle with LOAD=1 and held otherwise.
REQ-014 SHALL register nHEX, so a change of STATE, din_q or CURSOR appears exactly one cycle later.
REQ-015 SHALL display, in READY, 7'b0101111 ('r') on digit 0 and blank (7'b1111111) on all others.
REQ-016 SHALL display, in QUESTION, each que_q digit as decimal 0-9, with codes >9 blank.
REQ-017 SHALL display, in INPUT, din_q codes mapped 0->7'b0111111 ('-'), 1->2, 2->3, 3->5, 4->7, 5->1, 6->3, 7->7, 8->9, 9->3, with codes >9 blank.
REQ-018 SHALL blank, in INPUT, the CURSOR digit while blink phase=1; other digits do not blink.
REQ-019 SHALL display a letter on all digits in result states: GOOD 'O' 7'b1000000, WRONG 'A' 7'b0001000, OUCH 'U' 7'b1000001, DRAW 't' 7'b0000111, WIN 'E' 7'b0000110, LOSE 'O'.
REQ-020 SHALL blank all digits for any other STATE value.
REQ-021 SHALL implement the blink counter as 0..BLINK_DIV-1, wrapping to 0 and toggling phase on the wrap; it is cleared with phase=0 whenever STATE changes or CURSOR changes, so the edited digit is visible first.
REQ-022 SHALL ignore a CURSOR value >= NDIG, with no digit blinking.
REQ-023 SHALL capture new data when LOAD and a STATE change occur in the same cycle, and decode that data under the new STATE on the next cycle.

Reset
REQ-024 SHALL set, while nRST=0, nHEX all ones, nSEG=7'h7F, nAN all ones, din_q=que_q=0, blink counter and phase 0, and scan counter and index 0, asynchronously.
REQ-025 SHALL apply reset mid-scan or mid-blink immediately; the first non-blank nHEX appears one cycle after nRST deasserts with a valid STATE.

Configuration
REQ-026 SHALL, when macro SEG7_SCAN_EN is defined, cycle a scan index 0..NDIG-1, advancing every SCAN_DIV cycles and wrapping, with nAN having only bit[index] low and nSEG=nHEX slice[index], both registered.
REQ-027 SHALL, when SEG7_SCAN_EN is undefined, tie nSEG to 7'h7F and nAN to all ones and omit the scan logic; nHEX behaviour is unchanged in both cases.

Structure
REQ-028 SHALL place state encodings, glyph constants (digits, letters, blank, '-') and the INPUT prime map function in shared package seg7_pkg.
REQ-029 SHALL instantiate one sub-module, seg7_glyph (combinational: STATE, code, digit index to 7-bit glyph), NDIG times.

Verification
REQ-030 SHALL verify reset: nRST=0 mid-operation -> nHEX=all ones and nAN=all ones that same cycle.
REQ-031 SHALL verify INPUT: NDIG=4, LOAD with DIN=16'h4321 and STATE=0100 -> next cycle nHEX digits 0..3 show 2,3,5,7.
REQ-032 SHALL verify blink: BLINK_DIV=4, INPUT, CURSOR=1 -> digit 1 visible for 4 cycles, blank for 4 cycles, then repeats; changing CURSOR restarts the visible phase.
REQ-033 SHALL verify results: STATE=1010 -> all digits 7'b0000110; STATE=0101 -> all blank.
REQ-034 SHALL verify scan with SEG7_SCAN_EN and SCAN_DIV=2: nAN sequence 1110, 1101, 1011, 0111 each lasting 2 cycles, with nSEG matching the enabled digit.
REQ-035 SHALL verify that simultaneous LOAD and STATE change from READY to QUESTION with QUE=16'h0919 -> next cycle digits show 9,1,9,0.
